// File: rtl/usb_system_sysinfo_pkg.sv
// Shared address map, CTRL bit positions and byte-lane merge helper
// for the sysinfo register block.
package usb_system_sysinfo_pkg;

    localparam int ADDR_ID       = 0;
    localparam int ADDR_TS       = 1;
    localparam int ADDR_VER      = 2;
    localparam int ADDR_UPT_LO   = 3;
    localparam int ADDR_UPT_HI   = 4;
    localparam int ADDR_CTRL     = 5;
    localparam int ADDR_SCRATCH0 = 6;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        if (be[0]) merged[7:0]   = new_word[7:0];
        if (be[1]) merged[15:8]  = new_word[15:8];
        if (be[2]) merged[23:16] = new_word[23:16];
        if (be[3]) merged[31:24] = new_word[31:24];
        return merged;
    endfunction

endpackage

// File: rtl/usb_system_sysinfo_rdpipe.sv
// READ_LATENCY-deep valid/data delay line; data only advances with its valid
// so the output holds the last returned word, and reset flushes every stage.
module usb_system_sysinfo_rdpipe #(
    parameter int READ_LATENCY = 1,
    parameter int DATA_W       = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_data
);

    logic [READ_LATENCY:0]             w_vld;
    logic [READ_LATENCY:0][DATA_W-1:0] w_data;

    assign w_vld[0]  = i_vld;
    assign w_data[0] = i_data;

    for (genvar s = 0; s < READ_LATENCY; s++) begin : g_stage
        logic              r_vld_p;
        logic [DATA_W-1:0] r_data_p;

        // stage s -> s+1
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                r_vld_p  <= 1'b0;
                r_data_p <= '0;
            end else begin
                r_vld_p <= w_vld[s];
                if (w_vld[s]) r_data_p <= w_data[s];
            end
        end

        assign w_vld[s+1]  = r_vld_p;
        assign w_data[s+1] = r_data_p;
    end

    assign o_vld  = w_vld[READ_LATENCY];
    assign o_data = w_data[READ_LATENCY];

endmodule

// File: rtl/usb_system_sysinfo_regs.sv
// System-ID / housekeeping Avalon-MM slave: identity words, 64-bit uptime
// counter with coherent high-word snapshot, CTRL and scratch registers.
module usb_system_sysinfo_regs
    import usb_system_sysinfo_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'd1430756268,
    parameter logic [31:0] VERSION      = 32'h0001_0000,
    parameter int          ADDR_W       = 3,
    parameter int          NUM_SCRATCH  = 2,
    parameter int          READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    logic [31:0] w_addr;
    logic        w_wr_en;
    logic        w_ctrl_wr;
    logic        w_clr;
    logic [31:0] w_rd_word;

    logic [63:0] r_cnt;
    logic [31:0] r_snap;
    logic        r_ctrl_en;

    logic [NUM_SCRATCH:0][31:0] w_scr_rd;

    assign w_addr    = 32'(address);
    // A write coinciding with a read is dropped; the read wins.
    assign w_wr_en   = write & ~read;
    assign w_ctrl_wr = w_wr_en && (w_addr == 32'(ADDR_CTRL)) && byteenable[0];
    assign w_clr     = w_ctrl_wr && writedata[CTRL_CLR];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ctrl_en <= 1'b1;
        end else if (w_ctrl_wr) begin
            r_ctrl_en <= writedata[CTRL_EN];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || w_clr) begin
            r_cnt <= '0;
        end else if (r_ctrl_en) begin
            r_cnt <= r_cnt + 64'd1;
        end
    end

    // Reading the low word latches the high word from the same cycle.
    always_ff @(posedge clock) begin
        if (!reset_n || w_clr) begin
            r_snap <= '0;
        end else if (read && (w_addr == 32'(ADDR_UPT_LO))) begin
            r_snap <= r_cnt[63:32];
        end
    end

    assign w_scr_rd[0] = '0;

    for (genvar g = 0; g < NUM_SCRATCH; g++) begin : g_scratch
        logic [31:0] r_word;
        logic        w_hit;

        assign w_hit = (w_addr == 32'(ADDR_SCRATCH0 + g));

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                r_word <= '0;
            end else if (w_wr_en && w_hit) begin
                r_word <= merge_bytes(r_word, writedata, byteenable);
            end
        end

        assign w_scr_rd[g+1] = w_scr_rd[g] | (w_hit ? r_word : 32'h0);
    end

    always_comb begin
        w_rd_word = '0;
        case (w_addr)
            32'(ADDR_ID):     w_rd_word = SYSTEM_ID;
            32'(ADDR_TS):     w_rd_word = TIMESTAMP;
            32'(ADDR_VER):    w_rd_word = VERSION;
            32'(ADDR_UPT_LO): w_rd_word = r_cnt[31:0];
            32'(ADDR_UPT_HI): w_rd_word = r_snap;
            32'(ADDR_CTRL):   w_rd_word = {31'b0, r_ctrl_en};
            default:          w_rd_word = w_scr_rd[NUM_SCRATCH];
        endcase
    end

    usb_system_sysinfo_rdpipe #(
        .READ_LATENCY (READ_LATENCY),
        .DATA_W       (32)
    ) u_rdpipe (
        .clock   (clock),
        .reset_n (reset_n),
        .i_vld   (read),
        .i_data  (w_rd_word),
        .o_vld   (readdatavalid),
        .o_data  (readdata)
    );

endmodule

// File: tb/tb_usb_system_sysinfo_regs.sv
// Bench for usb_system_sysinfo_regs: two instances (read latency 1 and 3)
// share stimulus and are compared every cycle against a register-level model.
module tb_usb_system_sysinfo_regs;

    localparam logic [31:0] TS_VAL  = 32'd1430756268;
    localparam logic [31:0] VER_VAL = 32'h0001_0000;

    logic        clock;
    logic        reset_n;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] rd1, rd3;
    logic        rdv1, rdv3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    usb_system_sysinfo_regs #(
        .ADDR_W(4), .NUM_SCRATCH(2), .READ_LATENCY(1)
    ) dut_l1 (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(rd1), .readdatavalid(rdv1)
    );

    usb_system_sysinfo_regs #(
        .ADDR_W(4), .NUM_SCRATCH(2), .READ_LATENCY(3)
    ) dut_l3 (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(rd3), .readdatavalid(rdv3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: architectural register state plus expected-result queues.
    logic [63:0] m_cnt;
    logic [31:0] m_snap;
    logic        m_en;
    logic [31:0] m_scr0, m_scr1;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        q1[$];
    exp_t        q3[$];
    logic [31:0] last1, last3;

    typedef struct {
        logic        rd;
        logic        wr;
        int          addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[18];

    function automatic logic [31:0] model_read(input int a);
        case (a)
            0:       return 32'h0;
            1:       return TS_VAL;
            2:       return VER_VAL;
            3:       return m_cnt[31:0];
            4:       return m_snap;
            5:       return {31'b0, m_en};
            6:       return m_scr0;
            7:       return m_scr1;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++)
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        return res;
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr, input int a, input logic [31:0] wd,
                                input logic [3:0] be, input logic chk, input logic [31:0] exp);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd; v.be = be; v.chk = chk; v.exp = exp;
        return v;
    endfunction

    task automatic model_step(input logic rst_n, input logic rd, input logic wr, input int a,
                              input logic [31:0] wd, input logic [3:0] be);
        logic        clr;
        logic        en_next;
        logic [31:0] v;
        if (!rst_n) begin
            m_cnt = 64'h0; m_snap = 32'h0; m_en = 1'b1; m_scr0 = 32'h0; m_scr1 = 32'h0;
            q1.delete(); q3.delete();
            last1 = 32'h0; last3 = 32'h0;
        end else begin
            if (rd) begin
                v = model_read(a);
                q1.push_back('{cyc + 1, v});
                q3.push_back('{cyc + 3, v});
            end
            clr     = 1'b0;
            en_next = m_en;
            if (wr && !rd) begin
                if (a == 5 && be[0]) begin
                    en_next = wd[0];
                    clr     = wd[1];
                end
                if (a == 6) m_scr0 = lanes(m_scr0, wd, be);
                if (a == 7) m_scr1 = lanes(m_scr1, wd, be);
            end
            if (clr) begin
                m_cnt  = 64'h0;
                m_snap = 32'h0;
            end else begin
                if (rd && a == 3) m_snap = m_cnt[63:32];
                if (m_en) m_cnt = m_cnt + 64'd1;
            end
            m_en = en_next;
        end
    endtask

    task automatic compare_out(input string name, input logic av, input logic [31:0] ad,
                               input logic ev, input logic [31:0] ed);
        checks++;
        if (av !== ev || ad !== ed) begin
            errors++;
            $display("FAIL %s cyc=%0d got vld=%0b data=%h expected vld=%0b data=%h",
                     name, cyc, av, ad, ev, ed);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Called at a negedge: drive inputs, advance the model, clock, then compare.
    task automatic step(input logic rst_n, input logic rd, input logic wr, input int a,
                        input logic [31:0] wd, input logic [3:0] be);
        logic        ev;
        logic [31:0] ed;
        exp_t        e;
        reset_n    = rst_n;
        read       = rd;
        write      = wr;
        address    = 4'(a);
        writedata  = wd;
        byteenable = be;
        model_step(rst_n, rd, wr, a, wd, be);
        @(posedge clock);
        cyc++;
        @(negedge clock);
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front(); ev = 1'b1; ed = e.data; last1 = ed;
        end else begin
            ev = 1'b0; ed = last1;
        end
        compare_out("lat1", rdv1, rd1, ev, ed);
        if (q3.size() > 0 && q3[0].due == cyc) begin
            e = q3.pop_front(); ev = 1'b1; ed = e.data; last3 = ed;
        end else begin
            ev = 1'b0; ed = last3;
        end
        compare_out("lat3", rdv3, rd3, ev, ed);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 32'h0, 4'h0);
    endtask

    task automatic rd_op(input int a);
        step(1'b1, 1'b1, 1'b0, a, 32'h0, 4'h0);
    endtask

    task automatic wr_op(input int a, input logic [31:0] wd, input logic [3:0] be);
        step(1'b1, 1'b0, 1'b1, a, wd, be);
    endtask

    initial begin
        reset_n = 1'b0; read = 1'b0; write = 1'b0;
        address = 4'h0; writedata = 32'h0; byteenable = 4'h0;

        tbl[0]  = mk(1'b1, 1'b0, 0, 32'h0,        4'h0, 1'b1, 32'h0000_0000);
        tbl[1]  = mk(1'b1, 1'b0, 1, 32'h0,        4'h0, 1'b1, TS_VAL);
        tbl[2]  = mk(1'b1, 1'b0, 2, 32'h0,        4'h0, 1'b1, VER_VAL);
        tbl[3]  = mk(1'b0, 1'b1, 6, 32'hA5A5A5A5, 4'h3, 1'b0, 32'h0);
        tbl[4]  = mk(1'b1, 1'b0, 6, 32'h0,        4'h0, 1'b1, 32'h0000_A5A5);
        tbl[5]  = mk(1'b1, 1'b0, 9, 32'h0,        4'h0, 1'b1, 32'h0);
        tbl[6]  = mk(1'b0, 1'b1, 9, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0);
        tbl[7]  = mk(1'b1, 1'b0, 9, 32'h0,        4'h0, 1'b1, 32'h0);
        tbl[8]  = mk(1'b0, 1'b1, 0, 32'h12345678, 4'hF, 1'b0, 32'h0);
        tbl[9]  = mk(1'b1, 1'b0, 0, 32'h0,        4'h0, 1'b1, 32'h0);
        tbl[10] = mk(1'b1, 1'b0, 5, 32'h0,        4'h0, 1'b1, 32'h1);
        tbl[11] = mk(1'b0, 1'b1, 7, 32'hDEADBEEF, 4'hC, 1'b0, 32'h0);
        tbl[12] = mk(1'b1, 1'b0, 7, 32'h0,        4'h0, 1'b1, 32'hDEAD_0000);
        tbl[13] = mk(1'b1, 1'b1, 6, 32'h11111111, 4'hF, 1'b1, 32'h0000_A5A5);
        tbl[14] = mk(1'b1, 1'b0, 6, 32'h0,        4'h0, 1'b1, 32'h0000_A5A5);
        tbl[15] = mk(1'b0, 1'b1, 5, 32'h0,        4'hE, 1'b0, 32'h0);
        tbl[16] = mk(1'b1, 1'b0, 5, 32'h0,        4'h0, 1'b1, 32'h1);
        tbl[17] = mk(1'b1, 1'b0, 1, 32'h0,        4'h0, 1'b1, TS_VAL);

        @(negedge clock);
        step(1'b0, 1'b0, 1'b0, 0, 32'h0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1, 32'h0, 4'h0);
        chk("reset_rdata", rd1, 32'h0);
        chk("reset_rvalid", {31'b0, rdv3}, 32'h0);

        for (int i = 0; i < 18; i++) begin
            step(1'b1, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].be);
            if (tbl[i].chk) chk($sformatf("tbl%0d", i), rd1, tbl[i].exp);
        end

        // Latency-3 single read: pulse only on the third result cycle.
        idle(3);
        rd_op(1);
        chk("l3_c1_vld", {31'b0, rdv3}, 32'h0);
        idle(1);
        chk("l3_c2_vld", {31'b0, rdv3}, 32'h0);
        idle(1);
        chk("l3_c3_vld", {31'b0, rdv3}, 32'h1);
        chk("l3_c3_data", rd3, TS_VAL);
        idle(1);
        chk("l3_c4_vld", {31'b0, rdv3}, 32'h0);

        // Freeze: clear with en=1, then disable; counter stops at 1.
        wr_op(5, 32'h3, 4'h1);
        wr_op(5, 32'h0, 4'h1);
        idle(10);
        rd_op(3);
        chk("freeze_lo", rd1, 32'h1);
        rd_op(4);
        chk("freeze_hi", rd1, 32'h0);
        wr_op(5, 32'h3, 4'h1);
        rd_op(3);
        chk("clr_lo0", rd1, 32'h0);
        rd_op(3);
        chk("clr_lo1", rd1, 32'h1);
        rd_op(3);
        chk("clr_lo2", rd1, 32'h2);
        rd_op(5);
        chk("ctrl_rd", rd1, 32'h1);

        // Counter carry into the high word with snapshot coherence.
        force dut_l1.r_cnt = 64'h0000_0000_FFFF_FFFF;
        force dut_l3.r_cnt = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut_l1.r_cnt;
        release dut_l3.r_cnt;
        m_cnt = 64'h0000_0000_FFFF_FFFF;
        rd_op(3);
        chk("wrap_lo", rd1, 32'hFFFF_FFFF);
        rd_op(4);
        chk("wrap_hi", rd1, 32'h0);
        rd_op(3);
        chk("wrap_lo2", rd1, 32'h1);
        rd_op(4);
        chk("wrap_hi2", rd1, 32'h1);

        // Read then reset: the in-flight latency-3 result must vanish.
        idle(3);
        rd_op(2);
        step(1'b0, 1'b0, 1'b0, 0, 32'h0, 4'h0);
        chk("rst_mid_rd1", rd1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk($sformatf("rst_mid_vld%0d", i), {31'b0, rdv3}, 32'h0);
        end
        chk("rst_mid_rd3", rd3, 32'h0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom % 60) != 0, 1'(($urandom % 2) == 0), 1'(($urandom % 3) == 0),
                 int'($urandom % 16), $urandom, 4'($urandom % 16));
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
